demux_universal_gates: RTL and testbench

- Bitwise NAND and NOR computed purely from 1-to-2 demultiplexer primitives. No direct gate operators on the data path; decode-and-merge only.
- Per bit, a 2-level demux tree routes constant 1 to one of four minterm lines selected by {a,b]. The outputs are ORed combinations of those minterms.
- Results are registered, giving a 1-cycle pipeline stage.
- Used as a universal-gate building block and as a demux-based logic teaching/verification primitive.

---
 rtl/demux_gates_pkg.sv | 12 +
 rtl/demux_1to2.sv | 13 +
 rtl/demux_universal_gates.sv | 138 +++++++++++++
 tb/tb_demux_universal_gates.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/demux_gates_pkg.sv
// Shared constants for the demux-built universal gates.
package demux_gates_pkg;

    // Minterm line indices, index = {a,b}
    localparam int MT_00 = 0;
    localparam int MT_01 = 1;
    localparam int MT_10 = 2;
    localparam int MT_11 = 3;

    localparam logic OUT_RST = 1'b0;

endpackage

// File: rtl/demux_1to2.sv
// 1-to-2 demultiplexer primitive: din steered to y0 (sel=0) or y1 (sel=1).
module demux_1to2 (
    input  logic din,
    input  logic sel,
    output logic y0,
    output logic y1
);

    // Ternary form keeps an unknown select visible as X on both lines.
    assign y0 = sel ? 1'b0 : din;
    assign y1 = sel ? din  : 1'b0;

endmodule

// File: rtl/demux_universal_gates.sv
// Registered bitwise NAND/NOR built only from demux trees and minterm merging.
// Define DEMUX_GATES_ALL_EN to add registered AND/OR/XOR/XNOR outputs.
module demux_universal_gates
    import demux_gates_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DEMUX_GATES_ALL_EN
    output logic [WIDTH-1:0] and_g,
    output logic [WIDTH-1:0] or_g,
    output logic [WIDTH-1:0] xor_g,
    output logic [WIDTH-1:0] xnor_g,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] nand_g,
    output logic [WIDTH-1:0] nor_g
);

    logic [WIDTH-1:0]      h0;
    logic [WIDTH-1:0]      h1;
    logic [WIDTH-1:0][3:0] mt;
    logic [WIDTH-1:0]      nand_next;
    logic [WIDTH-1:0]      nor_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        demux_1to2 u_stage_a (
            .din (1'b1),
            .sel (a[i]),
            .y0  (h0[i]),
            .y1  (h1[i])
        );
        demux_1to2 u_stage_b0 (
            .din (h0[i]),
            .sel (b[i]),
            .y0  (mt[i][MT_00]),
            .y1  (mt[i][MT_01])
        );
        demux_1to2 u_stage_b1 (
            .din (h1[i]),
            .sel (b[i]),
            .y0  (mt[i][MT_10]),
            .y1  (mt[i][MT_11])
        );

        assign nand_next[i] = mt[i][MT_00] | mt[i][MT_01] | mt[i][MT_10];
        assign nor_next[i]  = mt[i][MT_00];
    end

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] nand_q;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_q;
    logic [WIDTH-1:0] nor_d;

    always_comb begin
        out_valid_d = in_valid;
        nand_d      = nand_q;
        nor_d       = nor_q;
        if (in_valid) begin
            nand_d = nand_next;
            nor_d  = nor_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            nand_q      <= {WIDTH{OUT_RST}};
            nor_q       <= {WIDTH{OUT_RST}};
        end else begin
            out_valid_q <= out_valid_d;
            nand_q      <= nand_d;
            nor_q       <= nor_d;
        end
    end

    assign out_valid = out_valid_q;
    assign nand_g    = nand_q;
    assign nor_g     = nor_q;

`ifdef DEMUX_GATES_ALL_EN
    logic [WIDTH-1:0] and_next;
    logic [WIDTH-1:0] or_next;
    logic [WIDTH-1:0] xor_next;
    logic [WIDTH-1:0] xnor_next;

    for (genvar j = 0; j < WIDTH; j++) begin : g_all
        assign and_next[j]  = mt[j][MT_11];
        assign or_next[j]   = mt[j][MT_01] | mt[j][MT_10] | mt[j][MT_11];
        assign xor_next[j]  = mt[j][MT_01] | mt[j][MT_10];
        assign xnor_next[j] = mt[j][MT_00] | mt[j][MT_11];
    end

    logic [WIDTH-1:0] and_q, and_d;
    logic [WIDTH-1:0] or_q, or_d;
    logic [WIDTH-1:0] xor_q, xor_d;
    logic [WIDTH-1:0] xnor_q, xnor_d;

    always_comb begin
        and_d  = and_q;
        or_d   = or_q;
        xor_d  = xor_q;
        xnor_d = xnor_q;
        if (in_valid) begin
            and_d  = and_next;
            or_d   = or_next;
            xor_d  = xor_next;
            xnor_d = xnor_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            and_q  <= {WIDTH{OUT_RST}};
            or_q   <= {WIDTH{OUT_RST}};
            xor_q  <= {WIDTH{OUT_RST}};
            xnor_q <= {WIDTH{OUT_RST}};
        end else begin
            and_q  <= and_d;
            or_q   <= or_d;
            xor_q  <= xor_d;
            xnor_q <= xnor_d;
        end
    end

    assign and_g  = and_q;
    assign or_g   = or_q;
    assign xor_g  = xor_q;
    assign xnor_g = xnor_q;
`endif

endmodule

// File: tb/tb_demux_universal_gates.sv
// Self-checking bench for demux_universal_gates: directed plan plus random stream vs a lane-sum model.
module tb_demux_universal_gates;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] nand_g;
    logic [W-1:0] nor_g;
`ifdef DEMUX_GATES_ALL_EN
    logic [W-1:0] and_g, or_g, xor_g, xnor_g;
    logic [W-1:0] m_and, m_or, m_xor, m_xnor;
`endif

    int total = 0;
    int bad   = 0;

    logic         m_valid;
    logic [W-1:0] m_nand;
    logic [W-1:0] m_nor;

    always #5 clk = ~clk;

    demux_universal_gates #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef DEMUX_GATES_ALL_EN
        .and_g     (and_g),
        .or_g      (or_g),
        .xor_g     (xor_g),
        .xnor_g    (xnor_g),
`endif
        .out_valid (out_valid),
        .nand_g    (nand_g),
        .nor_g     (nor_g)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: each lane's gate value depends only on how many of a[i], b[i] are 1.
    task automatic model_edge(input logic r, input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi);
        int ones;
        if (!r) begin
            m_valid = 1'b0;
            m_nand  = '0;
            m_nor   = '0;
`ifdef DEMUX_GATES_ALL_EN
            m_and = '0; m_or = '0; m_xor = '0; m_xnor = '0;
`endif
        end else begin
            m_valid = v;
            if (v) begin
                for (int i = 0; i < W; i++) begin
                    ones = int'(ai[i]) + int'(bi[i]);
                    m_nand[i] = (ones < 2);
                    m_nor[i]  = (ones == 0);
`ifdef DEMUX_GATES_ALL_EN
                    m_and[i]  = (ones == 2);
                    m_or[i]   = (ones >= 1);
                    m_xor[i]  = (ones == 1);
                    m_xnor[i] = (ones != 1);
`endif
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] ai, input logic [W-1:0] bi);
        rst_n    = r;
        in_valid = v;
        a        = ai;
        b        = bi;
        @(posedge clk);
        model_edge(r, v, ai, bi);
        #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".nand"},  32'(nand_g),    32'(m_nand));
        chk({tag, ".nor"},   32'(nor_g),     32'(m_nor));
`ifdef DEMUX_GATES_ALL_EN
        chk({tag, ".and"},  32'(and_g),  32'(m_and));
        chk({tag, ".or"},   32'(or_g),   32'(m_or));
        chk({tag, ".xor"},  32'(xor_g),  32'(m_xor));
        chk({tag, ".xnor"}, 32'(xnor_g), 32'(m_xnor));
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        m_valid = 1'b0; m_nand = '0; m_nor = '0;
`ifdef DEMUX_GATES_ALL_EN
        m_and = '0; m_or = '0; m_xor = '0; m_xnor = '0;
`endif
        #1;

        // reset dominates a valid 1/1 input
        step("rst0", 1'b0, 1'b1, '1, '1);
        step("rst1", 1'b0, 1'b1, '1, '1);
        chk("rst.nand_const", 32'(nand_g), 32'h0);
        chk("rst.nor_const",  32'(nor_g),  32'h0);

        // truth table, all lanes identical, back-to-back
        step("tt00", 1'b1, 1'b1, '0, '0);
        chk("tt00.nand_const", 32'(nand_g), 32'hF);
        chk("tt00.nor_const",  32'(nor_g),  32'hF);
        step("tt01", 1'b1, 1'b1, '0, '1);
        chk("tt01.nor_const",  32'(nor_g),  32'h0);
        step("tt10", 1'b1, 1'b1, '1, '0);
        step("tt11", 1'b1, 1'b1, '1, '1);
        chk("tt11.nand_const", 32'(nand_g), 32'h0);

        // hold while invalid
        step("hold0", 1'b1, 1'b0, '0, '0);
        step("hold1", 1'b1, 1'b0, '0, '0);
        step("hold2", 1'b1, 1'b0, '0, '0);
        chk("hold.nand_const", 32'(nand_g), 32'h0);

        // multi-lane pattern
        step("lane", 1'b1, 1'b1, 4'b1100, 4'b1010);
        chk("lane.nand_const", 32'(nand_g), 32'b0111);
        chk("lane.nor_const",  32'(nor_g),  32'b0001);
`ifdef DEMUX_GATES_ALL_EN
        chk("lane.and_const",  32'(and_g),  32'b1000);
        chk("lane.or_const",   32'(or_g),   32'b1110);
        chk("lane.xor_const",  32'(xor_g),  32'b0110);
        chk("lane.xnor_const", 32'(xnor_g), 32'b1001);
`endif

        // mid-stream reset then first valid after release
        step("ms0", 1'b1, 1'b1, 4'b0011, 4'b0101);
        step("msr", 1'b0, 1'b1, 4'b0000, 4'b0000);
        step("ms1", 1'b1, 1'b1, 4'b0110, 4'b0011);
        chk("ms1.nand_const", 32'(nand_g), 32'b1101);

        // random stream with occasional resets and bubbles
        for (int n = 0; n < 300; n++) begin
            step("rnd",
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
